scaled_image_panel: RTL and testbench

- Parametrised panel generator for one display half. It renders a 1-bit IMG_W×IMG_H image, enlarged by an integer SCALE and centred on a PANEL_W×PANEL_H background, with an optional border, grid overlay and invert mode.
- Image bits live in an internal double-buffered (ping-pong) store written by the preprocessing path. Banks swap only at frame boundaries, so a frame never shows a half-written image.
- Sits between the display timing/coordinate splitter and the panel mux, in the same slot as the existing fixed 28×28 panel.

---
 rtl/scaled_image_panel.sv | 237 +++++++++++++++++++++++
 tb/tb_scaled_image_panel.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scaled_image_panel.sv
// scaled_image_panel
// Renders a 1-bit IMG_W x IMG_H image, magnified by SCALE and centred on a
// PANEL_W x PANEL_H background, with optional border, cell grid and invert.
// Image bits live in a ping-pong store. The preprocessing path writes the back
// bank, and the banks swap only on frame_start, so a frame never shows a
// partially written image. Cell coordinates come from counters rather than
// division, so the pixel path has no dividers or multipliers. Output latency
// is a fixed two pixel clocks.
module scaled_image_panel #(
  parameter int          PANEL_W      = 512,
  parameter int          PANEL_H      = 768,
  parameter int          IMG_W        = 28,
  parameter int          IMG_H        = 28,
  parameter int          SCALE        = 10,
  parameter int          BORDER       = 2,
  parameter logic [15:0] COLOR_BG     = 16'h2104,
  parameter logic [15:0] COLOR_ON     = 16'hFFFF,
  parameter logic [15:0] COLOR_OFF    = 16'h0000,
  parameter logic [15:0] COLOR_BORDER = 16'hFFE0,
  parameter logic [15:0] COLOR_GRID   = 16'h4208,
  localparam int         ADDR_W       = $clog2(IMG_W * IMG_H)
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [10:0]       pixel_x,
  input  logic [10:0]       pixel_y,
  input  logic              pixel_valid,
  input  logic              frame_start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              wr_frame_done,
  input  logic              invert,
  input  logic              grid_en,
  output logic [15:0]       panel_pixel,
  output logic              panel_valid,
  output logic              bank_sel,
  output logic              swap_pending,
  output logic              img_ready
);

  localparam int IMG_PIX = IMG_W * IMG_H;
  localparam int IMG_XW  = IMG_W * SCALE;
  localparam int IMG_YH  = IMG_H * SCALE;
  localparam int X_OFF   = (PANEL_W - IMG_XW) / 2;
  localparam int Y_OFF   = (PANEL_H - IMG_YH) / 2;
  localparam int CXW     = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int COLW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROWW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // region decode
  int                px;
  int                py;
  logic              in_img;
  logic              in_brd;
  logic              img_pix;
  logic              h_load;
  logic              v_adv;

  // horizontal cell counters
  logic [CXW-1:0]    cx_q;
  logic [CXW-1:0]    cx_use;
  logic [CXW-1:0]    cx_nxt;
  logic [COLW-1:0]   col_q;
  logic [COLW-1:0]   col_use;
  logic [COLW-1:0]   col_nxt;

  // vertical cell counters
  logic [CXW-1:0]    cy_q;
  logic [ROWW-1:0]   row_q;
  logic [ADDR_W-1:0] row_base_q;

  logic [ADDR_W-1:0] rd_addr;
  logic              grid_hit;
  logic              swap;
  logic              wr_ok;

  // ping-pong image store (not cleared by reset)
  logic [IMG_PIX-1:0] bank0;
  logic [IMG_PIX-1:0] bank1;

  // pipeline stage 1
  logic              s1_valid;
  logic              s1_img;
  logic              s1_brd;
  logic              s1_grid;
  logic              s1_inv;
  logic [ADDR_W-1:0] s1_addr;

  // stage 2 combinational read and colour select
  logic              rd_bit;
  logic [15:0]       pix_nxt;

  // Classify the incoming coordinate as image, border or background.
  always_comb begin
    px      = int'(pixel_x);
    py      = int'(pixel_y);
    in_img  = (px >= X_OFF) && (px < X_OFF + IMG_XW) &&
              (py >= Y_OFF) && (py < Y_OFF + IMG_YH);
    in_brd  = !in_img &&
              (px >= X_OFF - BORDER) && (px < X_OFF + IMG_XW + BORDER) &&
              (py >= Y_OFF - BORDER) && (py < Y_OFF + IMG_YH + BORDER);
    img_pix = pixel_valid && in_img;
    h_load  = pixel_valid && (px == X_OFF);
    v_adv   = img_pix && (px == X_OFF + IMG_XW - 1);
  end

  // The first image column of a line starts at cell 0 in the same cycle,
  // so the loaded value is used directly rather than waiting for the register.
  always_comb begin
    cx_use  = h_load ? '0 : cx_q;
    col_use = h_load ? '0 : col_q;
    cx_nxt  = cx_use + CXW'(1);
    col_nxt = col_use;
    if (cx_use == CXW'(SCALE - 1)) begin
      cx_nxt  = '0;
      col_nxt = (col_use == COLW'(IMG_W - 1)) ? '0 : col_use + COLW'(1);
    end
    rd_addr  = row_base_q + ADDR_W'(col_use);
    grid_hit = (cx_use == '0) || (cy_q == '0);
  end

  // Horizontal sub-pixel and column counters step once per image pixel.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      cx_q  <= '0;
      col_q <= '0;
    end else if (img_pix) begin
      cx_q  <= cx_nxt;
      col_q <= col_nxt;
    end else if (h_load) begin
      cx_q  <= '0;
      col_q <= '0;
    end
  end

  // Vertical counters step on the last image pixel of each image line.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      cy_q       <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else if (frame_start) begin
      cy_q       <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else if (v_adv) begin
      if (cy_q == CXW'(SCALE - 1)) begin
        cy_q <= '0;
        if (row_q == ROWW'(IMG_H - 1)) begin
          row_q      <= '0;
          row_base_q <= '0;
        end else begin
          row_q      <= row_q + ROWW'(1);
          row_base_q <= row_base_q + ADDR_W'(IMG_W);
        end
      end else begin
        cy_q <= cy_q + CXW'(1);
      end
    end
  end

  // A completed back bank is swapped in at the next frame boundary; a done
  // pulse coinciding with frame_start swaps immediately.
  always_comb begin
    swap  = frame_start && (swap_pending || wr_frame_done);
    wr_ok = wr_en && (int'(wr_addr) < IMG_PIX);
  end

  // Bank select, pending flag and ready flag.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
      img_ready    <= 1'b0;
    end else if (swap) begin
      bank_sel     <= ~bank_sel;
      swap_pending <= 1'b0;
      img_ready    <= 1'b1;
    end else if (wr_frame_done) begin
      swap_pending <= 1'b1;
    end
  end

  // Writes always target the bank not on display.
  always_ff @(posedge pixel_clk) begin
    if (wr_ok) begin
      if (bank_sel) bank0[wr_addr] <= wr_data;
      else          bank1[wr_addr] <= wr_data;
    end
  end

  // Stage 1: register region, grid flag, read address and mode bits.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_img   <= 1'b0;
      s1_brd   <= 1'b0;
      s1_grid  <= 1'b0;
      s1_inv   <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= pixel_valid;
      s1_img   <= in_img;
      s1_brd   <= in_brd;
      s1_grid  <= grid_en && grid_hit;
      s1_inv   <= invert;
      s1_addr  <= rd_addr;
    end
  end

  // Front-bank read and colour priority for stage 2.
  always_comb begin
    rd_bit  = bank_sel ? bank1[s1_addr] : bank0[s1_addr];
    pix_nxt = COLOR_BG;
    if (s1_brd) begin
      pix_nxt = COLOR_BORDER;
    end else if (s1_img) begin
      if (s1_grid)                pix_nxt = COLOR_GRID;
      else if (!img_ready)        pix_nxt = COLOR_OFF;
      else if (rd_bit ^ s1_inv)   pix_nxt = COLOR_ON;
      else                        pix_nxt = COLOR_OFF;
    end
  end

  // Stage 2: output register; the pixel holds while no valid data arrives.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      panel_valid <= 1'b0;
      panel_pixel <= COLOR_BG;
    end else begin
      panel_valid <= s1_valid;
      if (s1_valid) panel_pixel <= pix_nxt;
    end
  end

endmodule

// File: tb/tb_scaled_image_panel.sv
// Bench for scaled_image_panel with default parameters. A frame-level model
// computes each pixel colour straight from its coordinate, and one compare
// process checks every output cycle against it two clocks after issue.
module tb_scaled_image_panel;
  localparam int XO = 116, YO = 244, S = 10, W = 28, H = 28, B = 2;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] pixel_x = '0;
  logic [10:0] pixel_y = '0;
  logic        pixel_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic        wr_data = 1'b0;
  logic        wr_frame_done = 1'b0;
  logic        invert = 1'b0;
  logic        grid_en = 1'b0;
  logic [15:0] panel_pixel;
  logic        panel_valid;
  logic        bank_sel;
  logic        swap_pending;
  logic        img_ready;

  int total = 0;
  int bad = 0;

  // model state
  bit m_bank[2][NPIX];
  int m_sel = 0;
  bit m_pend = 0;
  bit m_ready = 0;

  // issued pixel and its two-cycle delay line
  bit          cur_v = 0, cur_chk = 0, d1_v, d1_chk, d2_v, d2_chk;
  logic [15:0] cur_exp = '0, d1_exp, d2_exp;
  int          cur_key = 0, d1_key, d2_key;
  logic [15:0] seen[int];

  scaled_image_panel dut (
    .pixel_clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_frame_done(wr_frame_done),
    .invert(invert), .grid_en(grid_en), .panel_pixel(panel_pixel),
    .panel_valid(panel_valid), .bank_sel(bank_sel),
    .swap_pending(swap_pending), .img_ready(img_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(int x, int y, bit inv, bit grd);
    int dx = x - XO;
    int dy = y - YO;
    if (dx >= 0 && dx < W * S && dy >= 0 && dy < H * S) begin
      if (grd && ((dx % S) == 0 || (dy % S) == 0)) return 16'h4208;
      if (!m_ready) return 16'h0000;
      return (m_bank[m_sel][(dy / S) * W + dx / S] ^ inv) ? 16'hFFFF : 16'h0000;
    end
    if (dx >= -B && dx < W * S + B && dy >= -B && dy < H * S + B) return 16'hFFE0;
    return 16'h2104;
  endfunction

  function automatic bit pat(int kind, int a);
    case (kind)
      0:       return (a == 0) || (a == 1) || (a == 783);
      1:       return (a % 5) == 2;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_v <= 0; d2_v <= 0; d1_chk <= 0; d2_chk <= 0;
    end else begin
      d1_v <= cur_v; d1_chk <= cur_chk; d1_exp <= cur_exp; d1_key <= cur_key;
      d2_v <= d1_v;  d2_chk <= d1_chk;  d2_exp <= d1_exp;  d2_key <= d1_key;
    end
  end

  // Output must follow the issued pixel by exactly two clocks.
  always @(negedge clk) begin
    check("panel_valid", 32'(panel_valid), 32'(d2_v));
    if (d2_v && d2_chk)
      check($sformatf("pix(%0d,%0d)", d2_key / 2048, d2_key % 2048),
            32'(panel_pixel), 32'(d2_exp));
    if (d2_v) seen[d2_key] = panel_pixel;
  end

  task automatic pix(input int x, input int y, input bit chk);
    pixel_x = 11'(x); pixel_y = 11'(y); pixel_valid = 1'b1;
    cur_v = 1; cur_chk = chk; cur_key = x * 2048 + y;
    cur_exp = model_pix(x, y, invert, grid_en);
    @(posedge clk); #1;
    pixel_valid = 1'b0; cur_v = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input bit d);
    wr_en = 1'b1; wr_addr = 10'(a); wr_data = d;
    @(posedge clk);
    if (a < NPIX) m_bank[1 - m_sel][a] = d;
    #1 wr_en = 1'b0;
  endtask

  task automatic load_img(input int kind);
    for (int a = 0; a < NPIX; a++) wr(a, pat(kind, a));
  endtask

  task automatic done_pulse();
    wr_frame_done = 1'b1;
    @(posedge clk);
    m_pend = 1;
    #1 wr_frame_done = 1'b0;
  endtask

  // Image lines not listed are shortened to the line-advance pixel (unchecked)
  // plus one checked background pixel to its right.
  task automatic run_frame(input bit fd, input int l0, input int l1, input int l2);
    seen.delete();
    frame_start = 1'b1; wr_frame_done = fd;
    @(posedge clk);
    if (fd) m_pend = 1;
    if (m_pend) begin m_sel = 1 - m_sel; m_pend = 0; m_ready = 1; end
    #1 frame_start = 1'b0; wr_frame_done = 1'b0;
    idle(1);
    pix(0, 0, 1);
    pix(200, 100, 1);
    pix(115, 243, 1);
    for (int y = YO; y < YO + H * S; y++) begin
      if (y == l0 || y == l1 || y == l2) begin
        for (int x = XO - 3; x <= XO + W * S + 2; x++) pix(x, y, 1);
      end else begin
        pix(XO + W * S - 1, y, 0);
        pix(XO + W * S + 2, y, 1);
      end
    end
    pix(114, 524, 1);
    pix(397, 525, 1);
    pix(398, 526, 1);
    pix(511, 767, 1);
    idle(3);
  endtask

  task automatic lit(input string name, input int x, input int y, input logic [15:0] e);
    int k = x * 2048 + y;
    if (seen.exists(k)) check(name, 32'(seen[k]), 32'(e));
    else check(name, 32'hDEAD_BEEF, 32'(e));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(panel_valid), 32'h0);
    check("rst_pixel", 32'(panel_pixel), 32'h2104);
    rst = 1'b0;
    check("rst_bank_sel", 32'(bank_sel), 32'h0);
    check("rst_pending", 32'(swap_pending), 32'h0);
    check("rst_ready", 32'(img_ready), 32'h0);

    // reset in the middle of a live pixel stream
    frame_start = 1'b1; @(posedge clk); #1 frame_start = 1'b0;
    for (int i = 0; i < 5; i++) pix(XO + i, YO, 1);
    check("pre_rst_valid", 32'(panel_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(panel_valid), 32'h0);
    check("mid_rst_pixel", 32'(panel_pixel), 32'h2104);
    idle(2);
    rst = 1'b0; m_sel = 0; m_pend = 0; m_ready = 0;
    check("post_rst_bank_sel", 32'(bank_sel), 32'h0);
    check("post_rst_ready", 32'(img_ready), 32'h0);
    run_frame(0, 244, -1, -1);
    lit("not_ready_116_244", 116, 244, 16'h0000);

    // load and swap
    load_img(0);
    done_pulse();
    check("pending_set", 32'(swap_pending), 32'h1);
    check("no_swap_yet", 32'(bank_sel), 32'h0);
    run_frame(0, 244, 300, 523);
    check("swap_bank_sel", 32'(bank_sel), 32'h1);
    check("swap_pending_clr", 32'(swap_pending), 32'h0);
    check("swap_ready", 32'(img_ready), 32'h1);
    lit("on_116_244", 116, 244, 16'hFFFF);
    lit("on_126_244", 126, 244, 16'hFFFF);
    lit("on_395_523", 395, 523, 16'hFFFF);
    lit("off_136_244", 136, 244, 16'h0000);
    lit("brd_114_244", 114, 244, 16'hFFE0);
    lit("brd_397_525", 397, 525, 16'hFFE0);
    lit("bg_113_244", 113, 244, 16'h2104);
    lit("bg_0_0", 0, 0, 16'h2104);
    lit("bg_398_300", 398, 300, 16'h2104);

    // back bank written but no done pulse: display unchanged
    load_img(1);
    run_frame(0, 244, 523, -1);
    check("nodone_bank_sel", 32'(bank_sel), 32'h1);
    lit("nodone_116_244", 116, 244, 16'hFFFF);
    lit("nodone_136_244", 136, 244, 16'h0000);
    // done coinciding with frame_start swaps at once
    run_frame(1, 244, 523, -1);
    check("coinc_bank_sel", 32'(bank_sel), 32'h0);
    check("coinc_pending", 32'(swap_pending), 32'h0);
    lit("imgb_116_244", 116, 244, 16'h0000);
    lit("imgb_136_244", 136, 244, 16'hFFFF);

    // grid, then invert
    grid_en = 1'b1;
    run_frame(0, 244, 250, 523);
    lit("grid_126_250", 126, 250, 16'h4208);
    lit("cell_127_250", 127, 250, 16'h0000);
    lit("grid_136_244", 136, 244, 16'h4208);
    grid_en = 1'b0; invert = 1'b1;
    run_frame(0, 244, 250, 523);
    lit("inv_127_250", 127, 250, 16'hFFFF);
    lit("inv_136_244", 136, 244, 16'h0000);
    lit("inv_brd_114_244", 114, 244, 16'hFFE0);
    lit("inv_bg_0_0", 0, 0, 16'h2104);
    invert = 1'b0;

    // out-of-range write is ignored
    load_img(2);
    wr(784, 1'b1);
    done_pulse();
    run_frame(0, 244, 523, -1);
    check("oor_bank_sel", 32'(bank_sel), 32'h1);
    lit("oor_116_244", 116, 244, 16'h0000);
    lit("oor_126_244", 126, 244, 16'h0000);
    lit("oor_395_523", 395, 523, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
